vpu_alu_avg_seq: RTL and testbench

VPU_ALU_AVG_SEQ -- requirements
Module: vpu_alu_avg_seq

---
 rtl/vpu_alu_avg_seq.sv | 141 ++++++++++++++
 tb/tb_vpu_alu_avg_seq.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_alu_avg_seq.sv
// vpu_alu_avg_seq
// Sequences one averaging command over the AVG ALU. A command carries an
// element count and a 2-/3-operand mode. Each operand set taken from the SRC
// port is sent through the combinational ALU and captured in a single-entry
// output buffer on the DST port. The buffer can be drained and reloaded in the
// same cycle, so throughput is one element per cycle while DST keeps up.
// A zero-length command goes straight to DONE without any SRC or DST traffic.

module vpu_alu_avg_seq #(
    parameter int unsigned OPERAND_WIDTH   = 32,
    parameter int unsigned SRAM_R_PORT_CNT = 3,
    parameter int unsigned LEN_WIDTH       = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [LEN_WIDTH-1:0]       cmd_len,
    input  logic                       cmd_three,
    input  logic                       src_valid,
    output logic                       src_ready,
    output logic                       alu_en,
    output logic [SRAM_R_PORT_CNT-1:0] alu_op_valid,
    input  logic [OPERAND_WIDTH-1:0]   alu_result,
    output logic                       dst_valid,
    input  logic                       dst_ready,
    output logic [OPERAND_WIDTH-1:0]   dst_data,
    output logic                       dst_last,
    output logic                       busy,
    output logic                       done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]                 r_state;
    logic [LEN_WIDTH-1:0]       r_remaining;
    logic                       r_mode;
    logic                       r_dst_valid;
    logic                       r_dst_last;
    logic [OPERAND_WIDTH-1:0]   r_dst_data;

    logic                       w_cmd_accept;
    logic                       w_src_ready;
    logic                       w_fire;
    logic                       w_dst_hs;
    logic                       w_last_elem;
    logic [SRAM_R_PORT_CNT-1:0] w_op_mask;

    // The SRC port is only open in RUN, and only if the buffer is empty or being drained now
    always_comb begin
        w_cmd_accept = (r_state == ST_IDLE) && cmd_valid;
        w_src_ready  = (r_state == ST_RUN) && (!r_dst_valid || dst_ready);
        w_fire       = w_src_ready && src_valid;
        w_dst_hs     = r_dst_valid && dst_ready;
        w_last_elem  = (r_remaining == LEN_WIDTH'(1));
    end

    // Operand mask: the two base operands always, the third only in 3-operand mode
    always_comb begin
        w_op_mask = '0;
        if (w_fire) begin
            w_op_mask[0] = 1'b1;
            w_op_mask[1] = 1'b1;
            w_op_mask[2] = r_mode;
        end
    end

    // Control FSM: IDLE -> RUN -> DRAIN -> DONE -> IDLE, zero-length commands skip to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_accept) begin
                        r_state <= (cmd_len == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_fire && w_last_elem) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_dst_hs && r_dst_last) begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Element counter and mode are latched at acceptance; the counter stops at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remaining <= '0;
            r_mode      <= 1'b0;
        end else if (w_cmd_accept) begin
            r_remaining <= cmd_len;
            r_mode      <= cmd_three;
        end else if (w_fire && (r_remaining != '0)) begin
            r_remaining <= r_remaining - LEN_WIDTH'(1);
        end
    end

    // Single-entry output buffer: a fire reloads it even while it is being drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dst_valid <= 1'b0;
            r_dst_last  <= 1'b0;
            r_dst_data  <= '0;
        end else if (w_fire) begin
            r_dst_valid <= 1'b1;
            r_dst_last  <= w_last_elem;
            r_dst_data  <= alu_result;
        end else if (w_dst_hs) begin
            r_dst_valid <= 1'b0;
            r_dst_last  <= 1'b0;
        end
    end

    // Port outputs are decoded straight from state and the buffer registers
    always_comb begin
        cmd_ready    = (r_state == ST_IDLE);
        src_ready    = w_src_ready;
        alu_en       = w_fire;
        alu_op_valid = w_op_mask;
        dst_valid    = r_dst_valid;
        dst_last     = r_dst_last;
        dst_data     = r_dst_data;
        busy         = (r_state != ST_IDLE);
        done         = (r_state == ST_DONE);
    end

endmodule

// File: tb/tb_vpu_alu_avg_seq.sv
// tb_vpu_alu_avg_seq
// Self-checking bench for vpu_alu_avg_seq. The bench plays the AVG ALU and the
// SRC/DST ports. Expected elements go into a scoreboard queue when an operand
// set is accepted, and a DST monitor pops and compares them on each DST handshake.

module tb_vpu_alu_avg_seq;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_len;
    logic        cmd_three;
    logic        src_valid;
    logic        src_ready;
    logic        alu_en;
    logic [2:0]  alu_op_valid;
    logic [31:0] alu_result;
    logic        dst_valid;
    logic        dst_ready;
    logic [31:0] dst_data;
    logic        dst_last;
    logic        busy;
    logic        done;

    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [31:0] srcC;
    logic [33:0] aluSum2;
    logic [33:0] aluSum3;

    exp_t        sbQ[$];
    exp_t        monE;
    int          dstHsCyc[$];
    int          cyc;
    int          testsRun;
    int          failCount;

    vpu_alu_avg_seq #(
        .OPERAND_WIDTH   (32),
        .SRAM_R_PORT_CNT (3),
        .LEN_WIDTH       (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_len      (cmd_len),
        .cmd_three    (cmd_three),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .alu_en       (alu_en),
        .alu_op_valid (alu_op_valid),
        .alu_result   (alu_result),
        .dst_valid    (dst_valid),
        .dst_ready    (dst_ready),
        .dst_data     (dst_data),
        .dst_last     (dst_last),
        .busy         (busy),
        .done         (done)
    );

    // ALU model: floor average of two operands, or of three when the third operand is enabled
    assign aluSum2    = 34'(srcA) + 34'(srcB);
    assign aluSum3    = 34'(srcA) + 34'(srcB) + 34'(srcC);
    assign alu_result = alu_op_valid[2] ? 32'(aluSum3 / 34'd3) : 32'(aluSum2 >> 1);

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to time DST handshakes and the done pulse
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DST monitor: every DST handshake pops the scoreboard and compares data and last flag
    always @(negedge clk) begin
        if (rst_n === 1'b1 && dst_valid === 1'b1 && dst_ready === 1'b1) begin
            testsRun++;
            if (sbQ.size() == 0) begin
                failCount++;
                $display("[TB] FAIL dst_unexpected: got data=%0d last=%0b, expected no element", dst_data, dst_last);
            end else begin
                monE = sbQ.pop_front();
                if (dst_data !== monE.data || dst_last !== monE.last) begin
                    failCount++;
                    $display("[TB] FAIL dst_element: got data=%0d last=%0b, expected data=%0d last=%0b",
                             dst_data, dst_last, monE.data, monE.last);
                end
            end
            dstHsCyc.push_back(cyc);
        end
    end

    // Watchdog so the run always ends even if a handshake never arrives
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic issue_cmd(input logic [7:0] len, input logic three);
        int n;
        cmd_len   = len;
        cmd_three = three;
        cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        testsRun++;
        if (cmd_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL cmd_timeout: got cmd_ready=%0b, expected 1 within 20 cycles", cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drive_elem(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                              input logic [31:0] expData, input logic expLast, input logic [2:0] expOpv);
        int n;
        srcA      = a;
        srcB      = b;
        srcC      = c;
        src_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (src_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        testsRun++;
        if (src_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL src_timeout: got src_ready=%0b, expected 1 within 20 cycles", src_ready);
        end else begin
            sbQ.push_back('{data: expData, last: expLast});
            testsRun++;
            if (alu_en !== 1'b1 || alu_op_valid !== expOpv) begin
                failCount++;
                $display("[TB] FAIL alu_ctrl: got alu_en=%0b alu_op_valid=%b, expected alu_en=1 alu_op_valid=%b",
                         alu_en, alu_op_valid, expOpv);
            end
        end
        @(posedge clk);
        #1;
        src_valid = 1'b0;
    endtask

    task automatic wait_done(output int doneCyc);
        int n;
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        testsRun++;
        if (done !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL done_timeout: got done=%0b, expected 1 within 50 cycles", done);
        end
        doneCyc = cyc;
    endtask

    task automatic test_reset();
        #1;
        testsRun++;
        if (cmd_ready !== 1'b1 || src_ready !== 1'b0 || alu_en !== 1'b0 || alu_op_valid !== 3'b000 ||
            dst_valid !== 1'b0 || dst_last !== 1'b0 || dst_data !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs: got cmd_ready=%0b src_ready=%0b alu_en=%0b opv=%b dst_valid=%0b dst_last=%0b dst_data=%0d busy=%0b done=%0b, expected 1 0 0 000 0 0 0 0 0",
                     cmd_ready, src_ready, alu_en, alu_op_valid, dst_valid, dst_last, dst_data, busy, done);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        testsRun++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || dst_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_release: got cmd_ready=%0b busy=%0b dst_valid=%0b, expected 1 0 0",
                     cmd_ready, busy, dst_valid);
        end
    endtask

    task automatic test_two_op();
        int dc;
        $display("[TB] two-operand average, len 3");
        dstHsCyc.delete();
        dst_ready = 1'b1;
        issue_cmd(8'd3, 1'b0);
        drive_elem(32'd4, 32'd6, 32'd0, 32'd5, 1'b0, 3'b011);
        drive_elem(32'd7, 32'd8, 32'd0, 32'd7, 1'b0, 3'b011);
        drive_elem(32'd0, 32'd1, 32'd0, 32'd0, 1'b1, 3'b011);
        wait_done(dc);
        testsRun++;
        if (dstHsCyc.size() != 3) begin
            failCount++;
            $display("[TB] FAIL two_op_count: got %0d dst handshakes, expected 3", dstHsCyc.size());
        end else begin
            testsRun++;
            if (dstHsCyc[1] != dstHsCyc[0] + 1 || dstHsCyc[2] != dstHsCyc[1] + 1) begin
                failCount++;
                $display("[TB] FAIL two_op_throughput: got dst cycles %0d %0d %0d, expected consecutive",
                         dstHsCyc[0], dstHsCyc[1], dstHsCyc[2]);
            end
            testsRun++;
            if (dc != dstHsCyc[2] + 1) begin
                failCount++;
                $display("[TB] FAIL done_timing: got done at cycle %0d, expected %0d", dc, dstHsCyc[2] + 1);
            end
        end
        @(negedge clk);
        testsRun++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL done_pulse: got done=%0b cmd_ready=%0b busy=%0b, expected 0 1 0", done, cmd_ready, busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_three_op();
        int dc;
        $display("[TB] three-operand average, len 2");
        dst_ready = 1'b1;
        issue_cmd(8'd2, 1'b1);
        drive_elem(32'd3, 32'd6, 32'd9, 32'd6, 1'b0, 3'b111);
        drive_elem(32'd1, 32'd1, 32'd2, 32'd1, 1'b1, 3'b111);
        wait_done(dc);
        @(negedge clk);
        testsRun++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL three_op_end: got done=%0b busy=%0b, expected 0 0", done, busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int dc;
        $display("[TB] DST backpressure, len 2");
        dst_ready = 1'b0;
        issue_cmd(8'd2, 1'b0);
        drive_elem(32'd10, 32'd20, 32'd0, 32'd15, 1'b0, 3'b011);
        srcA      = 32'd2;
        srcB      = 32'd4;
        srcC      = 32'd0;
        src_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            testsRun++;
            if (src_ready !== 1'b0 || alu_en !== 1'b0 || dst_valid !== 1'b1 || dst_data !== 32'd15 || dst_last !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL stall_hold: got src_ready=%0b alu_en=%0b dst_valid=%0b dst_data=%0d dst_last=%0b, expected 0 0 1 15 0",
                         src_ready, alu_en, dst_valid, dst_data, dst_last);
            end
        end
        @(posedge clk);
        #1;
        dst_ready = 1'b1;
        drive_elem(32'd2, 32'd4, 32'd0, 32'd3, 1'b1, 3'b011);
        @(negedge clk);
        testsRun++;
        if (dst_valid !== 1'b1 || dst_data !== 32'd3 || dst_last !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL reload: got dst_valid=%0b dst_data=%0d dst_last=%0b, expected 1 3 1", dst_valid, dst_data, dst_last);
        end
        wait_done(dc);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero_len();
        $display("[TB] zero-length command");
        dst_ready = 1'b1;
        issue_cmd(8'd0, 1'b0);
        @(negedge clk);
        testsRun++;
        if (busy !== 1'b1 || done !== 1'b1 || alu_en !== 1'b0 || src_ready !== 1'b0 || dst_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL zero_len_done: got busy=%0b done=%0b alu_en=%0b src_ready=%0b dst_valid=%0b, expected 1 1 0 0 0",
                     busy, done, alu_en, src_ready, dst_valid);
        end
        @(negedge clk);
        testsRun++;
        if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1 || alu_en !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL zero_len_idle: got busy=%0b done=%0b cmd_ready=%0b alu_en=%0b, expected 0 0 1 0",
                     busy, done, cmd_ready, alu_en);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int dc;
        $display("[TB] reset during RUN");
        dst_ready = 1'b1;
        issue_cmd(8'd8, 1'b0);
        drive_elem(32'd2, 32'd2, 32'd0, 32'd2, 1'b0, 3'b011);
        drive_elem(32'd4, 32'd4, 32'd0, 32'd4, 1'b0, 3'b011);
        drive_elem(32'd6, 32'd6, 32'd0, 32'd6, 1'b0, 3'b011);
        testsRun++;
        if (dst_valid !== 1'b1 || busy !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL pre_reset: got dst_valid=%0b busy=%0b, expected 1 1", dst_valid, busy);
        end
        rst_n     = 1'b0;
        src_valid = 1'b0;
        #1;
        testsRun++;
        if (dst_valid !== 1'b0 || dst_last !== 1'b0 || dst_data !== 32'd0 || busy !== 1'b0 || done !== 1'b0 ||
            cmd_ready !== 1'b1 || src_ready !== 1'b0 || alu_en !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL async_reset: got dst_valid=%0b dst_last=%0b dst_data=%0d busy=%0b done=%0b cmd_ready=%0b src_ready=%0b alu_en=%0b, expected 0 0 0 0 0 1 0 0",
                     dst_valid, dst_last, dst_data, busy, done, cmd_ready, src_ready, alu_en);
        end
        sbQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        testsRun++;
        if (cmd_ready !== 1'b1 || dst_valid !== 1'b0 || busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL post_reset: got cmd_ready=%0b dst_valid=%0b busy=%0b, expected 1 0 0", cmd_ready, dst_valid, busy);
        end
        issue_cmd(8'd1, 1'b0);
        drive_elem(32'd9, 32'd11, 32'd0, 32'd10, 1'b1, 3'b011);
        wait_done(dc);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_cmd_in_run();
        int dc;
        $display("[TB] cmd_valid held during RUN");
        dst_ready = 1'b1;
        cmd_len   = 8'd2;
        cmd_three = 1'b0;
        cmd_valid = 1'b1;
        @(negedge clk);
        testsRun++;
        if (cmd_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL first_accept: got cmd_ready=%0b, expected 1", cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_len   = 8'd1;
        cmd_three = 1'b1;
        @(negedge clk);
        testsRun++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL cmd_ignored: got cmd_ready=%0b busy=%0b, expected 0 1", cmd_ready, busy);
        end
        @(posedge clk);
        #1;
        drive_elem(32'd5, 32'd7, 32'd0, 32'd6, 1'b0, 3'b011);
        drive_elem(32'd1, 32'd3, 32'd0, 32'd2, 1'b1, 3'b011);
        wait_done(dc);
        @(negedge clk);
        testsRun++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reaccept_idle: got cmd_ready=%0b busy=%0b, expected 1 0", cmd_ready, busy);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        testsRun++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reaccept_taken: got busy=%0b cmd_ready=%0b, expected 1 0", busy, cmd_ready);
        end
        @(posedge clk);
        #1;
        drive_elem(32'd3, 32'd3, 32'd3, 32'd3, 1'b1, 3'b111);
        wait_done(dc);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Test sequence
    initial begin
        testsRun  = 0;
        failCount = 0;
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        cmd_len   = 8'd0;
        cmd_three = 1'b0;
        src_valid = 1'b0;
        dst_ready = 1'b0;
        srcA      = 32'd0;
        srcB      = 32'd0;
        srcC      = 32'd0;
        #2;
        rst_n = 1'b0;
        test_reset();
        test_two_op();
        test_three_op();
        test_backpressure();
        test_zero_len();
        test_reset_mid();
        test_cmd_in_run();
        testsRun++;
        if (sbQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending elements, expected 0", sbQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
